// File: rtl/port_a_arbiter.sv
// ---------------------------------------------------------------------------
// port_a_arbiter
//
// Round-robin arbiter that lets two Avalon-MM masters share the s1 port of an
// 8-bit PIO (0 data, 1 direction, 2 irq mask, 3 edge capture, 4 set bits,
// 5 clear bits). Each grant produces exactly one registered slave command.
// The slave's 1-cycle registered read data is broadcast to both masters and
// qualified per master by a readdatavalid strobe.
//
// Ports
//   clk, reset              system clock; asynchronous active-high reset
//   m0_* / m1_*             master request (address, chipselect, write_n,
//                           writedata) and response (waitrequest, readdata,
//                           readdatavalid)
//   s_address, s_chipselect,
//   s_write_n, s_writedata  registered command to the PIO slave
//   s_readdata              PIO read data, one cycle after the read command
// ---------------------------------------------------------------------------
module port_a_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic                  m0_chipselect,
    input  logic                  m0_write_n,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic                  m1_chipselect,
    input  logic                  m1_write_n,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_WIDTH-1:0] s_address,
    output logic                  s_chipselect,
    output logic                  s_write_n,
    output logic [DATA_WIDTH-1:0] s_writedata,
    input  logic [DATA_WIDTH-1:0] s_readdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic grant;       // master owning the current ISSUE cycle
    logic last;        // most recently granted master
    logic rd_pend;     // read data from the slave is valid this cycle
    logic rd_owner;    // master that issued that read

    logic elig0;
    logic elig1;
    logic win;
    logic winner;

    // The master being served in ISSUE still holds chipselect for the
    // transfer that is completing; it must not be granted again off that.
    always_comb begin
        elig0     = 1'b0;
        elig1     = 1'b0;
        win       = 1'b0;
        winner    = 1'b0;
        state_nxt = IDLE;

        elig0  = m0_chipselect && !(state == ISSUE && grant == 1'b0);
        elig1  = m1_chipselect && !(state == ISSUE && grant == 1'b1);
        win    = elig0 || elig1;
        // On a tie the master that was not granted last time wins.
        winner = (elig0 && elig1) ? ~last : elig1;

        if (win) begin
            state_nxt = ISSUE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command register stage: the winner's request becomes the slave command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant        <= 1'b0;
            last         <= 1'b1;
            s_chipselect <= 1'b0;
            s_write_n    <= 1'b1;
            s_address    <= '0;
            s_writedata  <= '0;
        end else if (win) begin
            grant        <= winner;
            last         <= winner;
            s_chipselect <= 1'b1;
            s_address    <= winner ? m1_address   : m0_address;
            s_write_n    <= winner ? m1_write_n   : m0_write_n;
            s_writedata  <= winner ? m1_writedata : m0_writedata;
        end else begin
            s_chipselect <= 1'b0;
            s_write_n    <= 1'b1;
        end
    end

    // Read return stage: a read on the slave this cycle returns data next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= (state == ISSUE) && s_write_n;
            rd_owner <= grant;
        end
    end

    assign m0_waitrequest   = ~(state == ISSUE && grant == 1'b0);
    assign m1_waitrequest   = ~(state == ISSUE && grant == 1'b1);

    assign m0_readdatavalid = rd_pend && (rd_owner == 1'b0);
    assign m1_readdatavalid = rd_pend && (rd_owner == 1'b1);

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

endmodule

// File: tb/tb_port_a_arbiter.sv
// ---------------------------------------------------------------------------
// tb_port_a_arbiter
//
// Bench for port_a_arbiter: two queue-driven Avalon masters, a small PIO
// slave model, a transaction-level reference model of the arbiter checked
// every cycle, and directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_port_a_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;

    logic [AW-1:0] m0_address    = '0;
    logic          m0_chipselect = 1'b0;
    logic          m0_write_n    = 1'b1;
    logic [DW-1:0] m0_writedata  = '0;
    logic          m0_waitrequest;
    logic [DW-1:0] m0_readdata;
    logic          m0_readdatavalid;

    logic [AW-1:0] m1_address    = '0;
    logic          m1_chipselect = 1'b0;
    logic          m1_write_n    = 1'b1;
    logic [DW-1:0] m1_writedata  = '0;
    logic          m1_waitrequest;
    logic [DW-1:0] m1_readdata;
    logic          m1_readdatavalid;

    logic [AW-1:0] s_address;
    logic          s_chipselect;
    logic          s_write_n;
    logic [DW-1:0] s_writedata;
    logic [DW-1:0] s_readdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    port_a_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_chipselect    (m0_chipselect),
        .m0_write_n       (m0_write_n),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_chipselect    (m1_chipselect),
        .m1_write_n       (m1_write_n),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_chipselect     (s_chipselect),
        .s_write_n        (s_write_n),
        .s_writedata      (s_writedata),
        .s_readdata       (s_readdata)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: register file, set/clear on 4/5, registered read data.
    logic [7:0] pio [0:5] = '{default: 8'h00};

    always @(posedge clk) begin
        if (s_chipselect) begin
            if (!s_write_n) begin
                case (s_address)
                    3'd0, 3'd1, 3'd2, 3'd3: pio[s_address] <= s_writedata[7:0];
                    3'd4: pio[0] <= pio[0] | s_writedata[7:0];
                    3'd5: pio[0] <= pio[0] & ~s_writedata[7:0];
                    default: ;
                endcase
            end else begin
                s_readdata <= {24'h0, (s_address <= 3'd5) ? pio[s_address] : 8'h00};
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // own: master whose command is on the slave this cycle (-1 = none).
    int          own    = -1;
    int          rv_own = -1;
    int          w;
    logic        e_cs   = 1'b0;
    logic        e_wn   = 1'b1;
    logic        e_last = 1'b1;
    logic [2:0]  e_addr = '0;
    logic [31:0] e_wd   = '0;
    logic [31:0] e_rd   = '0;
    logic [7:0]  mem [0:5] = '{default: 8'h00};

    function automatic int pick(logic cs0, logic cs1, int cur, logic lst);
        logic e0, e1;
        e0 = cs0 && (cur != 0);
        e1 = cs1 && (cur != 1);
        if (e0 && e1) return lst ? 0 : 1;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    function automatic logic [7:0] mem_rd(logic [2:0] a);
        return (a <= 3'd5) ? mem[a] : 8'h00;
    endfunction

    always_comb w = pick(m0_chipselect, m1_chipselect, own, e_last);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            own    <= -1;
            rv_own <= -1;
            e_cs   <= 1'b0;
            e_wn   <= 1'b1;
            e_addr <= '0;
            e_wd   <= '0;
            e_last <= 1'b1;
            e_rd   <= '0;
        end else begin
            rv_own <= (own >= 0 && e_wn) ? own : -1;
            if (own >= 0 && e_wn) e_rd <= {24'h0, mem_rd(e_addr)};
            if (own >= 0 && !e_wn) begin
                case (e_addr)
                    3'd0, 3'd1, 3'd2, 3'd3: mem[e_addr] <= e_wd[7:0];
                    3'd4: mem[0] <= mem[0] | e_wd[7:0];
                    3'd5: mem[0] <= mem[0] & ~e_wd[7:0];
                    default: ;
                endcase
            end
            own  <= w;
            e_cs <= (w >= 0);
            if (w == 0) begin
                e_addr <= m0_address; e_wn <= m0_write_n; e_wd <= m0_writedata; e_last <= 1'b0;
            end else if (w == 1) begin
                e_addr <= m1_address; e_wn <= m1_write_n; e_wd <= m1_writedata; e_last <= 1'b1;
            end else begin
                e_wn <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m0_waitrequest", m0_waitrequest, own != 0);
            chk("m1_waitrequest", m1_waitrequest, own != 1);
            chk("s_chipselect", s_chipselect, e_cs);
            chk("s_write_n", s_write_n, e_wn);
            chk("s_address", s_address, e_addr);
            chk("s_writedata", s_writedata, e_wd);
            chk("m0_readdatavalid", m0_readdatavalid, rv_own == 0);
            chk("m1_readdatavalid", m1_readdatavalid, rv_own == 1);
            if (rv_own == 0) chk("m0_readdata", m0_readdata, e_rd);
            if (rv_own == 1) chk("m1_readdata", m1_readdata, e_rd);
        end
    end

    // ---------------- event logs for the directed checks ----------------
    typedef struct { int c; int who; logic [31:0] d; } ev_t;
    ev_t iss_q[$];
    ev_t rv_q[$];

    always @(negedge clk) begin
        if (s_chipselect === 1'b1)
            iss_q.push_back('{cyc, (m0_waitrequest === 1'b0) ? 0 : 1, s_writedata});
        if (m0_readdatavalid === 1'b1)
            rv_q.push_back('{cyc, 0, m0_readdata});
        else if (m1_readdatavalid === 1'b1)
            rv_q.push_back('{cyc, 1, m1_readdata});
    end

    function automatic int iss_c(int i);   return (iss_q.size() > i) ? iss_q[i].c   : -1; endfunction
    function automatic int iss_who(int i); return (iss_q.size() > i) ? iss_q[i].who : -1; endfunction
    function automatic int rv_c(int i);    return (rv_q.size() > i)  ? rv_q[i].c    : -1; endfunction
    function automatic int rv_who(int i);  return (rv_q.size() > i)  ? rv_q[i].who  : -1; endfunction
    function automatic logic [31:0] rv_d(int i); return (rv_q.size() > i) ? rv_q[i].d : 32'hdead; endfunction

    // ---------------- master drivers ----------------
    typedef struct { logic [2:0] a; logic wr; logic [31:0] d; } txn_t;
    txn_t q0[$];
    txn_t q1[$];
    int   req0_q[$];
    int   req1_q[$];

    task automatic step();
        txn_t t;
        @(negedge clk);
        if (m0_chipselect && !m0_waitrequest) m0_chipselect = 1'b0;
        if (m1_chipselect && !m1_waitrequest) m1_chipselect = 1'b0;
        if (!m0_chipselect && q0.size() > 0) begin
            t = q0.pop_front();
            m0_address = t.a; m0_write_n = !t.wr; m0_writedata = t.d; m0_chipselect = 1'b1;
            req0_q.push_back(cyc);
        end
        if (!m1_chipselect && q1.size() > 0) begin
            t = q1.pop_front();
            m1_address = t.a; m1_write_n = !t.wr; m1_writedata = t.d; m1_chipselect = 1'b1;
            req1_q.push_back(cyc);
        end
    endtask

    task automatic run(input int bound);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m0_chipselect || m1_chipselect) && n < bound) begin
            step();
            n++;
        end
        chk("run_completes_in_bound", n < bound, 1'b1);
        repeat (3) step();
    endtask

    task automatic clear_logs();
        iss_q.delete(); rv_q.delete(); req0_q.delete(); req1_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        #1;
        chk_en = 1'b1;

        // Reset state
        chk("rst_m0_waitrequest", m0_waitrequest, 1'b1);
        chk("rst_m1_waitrequest", m1_waitrequest, 1'b1);
        chk("rst_s_chipselect", s_chipselect, 1'b0);
        chk("rst_s_write_n", s_write_n, 1'b1);
        chk("rst_s_address", s_address, 32'h0);
        chk("rst_s_writedata", s_writedata, 32'h0);
        chk("rst_readdatavalid", {m0_readdatavalid, m1_readdatavalid}, 32'h0);

        // Single write: m0 writes 0x5A to data register
        clear_logs();
        q0.push_back('{3'd0, 1'b1, 32'h5A});
        run(20);
        chk("wr_issue_count", iss_q.size(), 1);
        chk("wr_issue_cycle", iss_c(0), req0_q[0] + 1);
        chk("wr_issue_owner", iss_who(0), 0);
        chk("wr_slave_data", pio[0], 8'h5A);

        // Single read: direction = 0xF0 (written by m0), then m1 reads it
        q0.push_back('{3'd1, 1'b1, 32'hF0});
        run(20);
        clear_logs();
        q1.push_back('{3'd1, 1'b0, 32'h0});
        run(20);
        chk("rd_issue_cycle", iss_c(0), req1_q[0] + 1);
        chk("rd_issue_owner", iss_who(0), 1);
        chk("rd_return_count", rv_q.size(), 1);
        chk("rd_return_cycle", rv_c(0), req1_q[0] + 2);
        chk("rd_return_owner", rv_who(0), 1);
        chk("rd_return_data", rv_d(0), 32'hF0);

        // Simultaneous requests after reset: set then clear
        @(posedge clk); #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        q0.push_back('{3'd4, 1'b1, 32'h01});
        q1.push_back('{3'd5, 1'b1, 32'h80});
        run(20);
        chk("sim_issue_count", iss_q.size(), 2);
        chk("sim_first_cycle", iss_c(0), req0_q[0] + 1);
        chk("sim_first_owner", iss_who(0), 0);
        chk("sim_first_data", (iss_q.size() > 0) ? iss_q[0].d : 32'hdead, 32'h01);
        chk("sim_second_cycle", iss_c(1), req1_q[0] + 2);
        chk("sim_second_owner", iss_who(1), 1);
        chk("sim_slave_data", pio[0], 8'h5B);

        // Continuous contention: 10 reads each, alternating issue and return
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            q0.push_back('{3'd0, 1'b0, 32'h0});
            q1.push_back('{3'd0, 1'b0, 32'h0});
        end
        run(80);
        chk("cont_issue_count", iss_q.size(), 20);
        chk("cont_return_count", rv_q.size(), 20);
        begin
            int n0 = 0;
            for (int i = 0; i < 20; i++) begin
                chk("cont_issue_cycle", iss_c(i), req0_q[0] + 1 + i);
                chk("cont_issue_owner", iss_who(i), i % 2);
                chk("cont_return_cycle", rv_c(i), iss_c(i) + 1);
                chk("cont_return_owner", rv_who(i), i % 2);
                chk("cont_return_data", rv_d(i), 32'h5B);
                if (iss_who(i) == 0) n0++;
            end
            chk("cont_m0_issues", n0, 10);
        end

        // Same-master back-to-back reads: one idle slave cycle between issues
        clear_logs();
        for (int i = 0; i < 3; i++) q0.push_back('{3'd1, 1'b0, 32'h0});
        run(30);
        chk("b2b_issue_count", iss_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_issue_cycle", iss_c(i), req0_q[0] + 1 + 2 * i);
            chk("b2b_issue_owner", iss_who(i), 0);
        end

        // Reset during m1's read ISSUE cycle: no read return
        clear_logs();
        q1.push_back('{3'd1, 1'b0, 32'h0});
        step();
        @(posedge clk);
        #2 reset = 1'b1;
        m1_chipselect = 1'b0;
        #1;
        chk("rstmid_m1_waitrequest", m1_waitrequest, 1'b1);
        chk("rstmid_s_chipselect", s_chipselect, 1'b0);
        chk("rstmid_s_write_n", s_write_n, 1'b1);
        chk("rstmid_readdatavalid", {m0_readdatavalid, m1_readdatavalid}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) step();
        chk("rstmid_no_return", rv_q.size(), 0);
        chk("rstmid_no_issue", iss_q.size(), 0);
        chk("rstmid_m0_waitrequest", m0_waitrequest, 1'b1);
        chk("rstmid_m1_wait_after", m1_waitrequest, 1'b1);
        q0.push_back('{3'd1, 1'b0, 32'h0});
        q1.push_back('{3'd1, 1'b0, 32'h0});
        run(20);
        chk("rstmid_tie_first", iss_who(0), 0);
        chk("rstmid_tie_second", iss_who(1), 1);
        chk("rstmid_tie_data", rv_d(0), 32'hF0);

        // Withdrawn request: m1 loses the tie, then drops chipselect
        clear_logs();
        @(negedge clk);
        m0_address = 3'd0; m0_write_n = 1'b1; m0_chipselect = 1'b1;
        m1_address = 3'd0; m1_write_n = 1'b1; m1_chipselect = 1'b1;
        @(negedge clk);
        m1_chipselect = 1'b0;
        @(negedge clk);
        m0_chipselect = 1'b0;
        repeat (4) @(negedge clk);
        chk("wd_issue_count", iss_q.size(), 1);
        chk("wd_issue_owner", iss_who(0), 0);
        chk("wd_m1_waitrequest", m1_waitrequest, 1'b1);
        q1.push_back('{3'd0, 1'b0, 32'h0});
        run(20);
        chk("wd_recover_count", iss_q.size(), 2);
        chk("wd_recover_owner", iss_who(1), 1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
